// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types, frame defaults and helpers for the 3x3 window engine
package conv_pkg;

  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_MAC,
    S_DONE
  } state_e;

  // Row/column offset of each tap relative to the centre pixel, row-major.
  localparam int TAP_DR [9] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
  localparam int TAP_DC [9] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};

  function automatic logic [7:0] clamp_u8(input logic signed [31:0] v);
    if (v < 0) begin
      return 8'd0;
    end else if (v > 255) begin
      return 8'hFF;
    end else begin
      return v[7:0];
    end
  endfunction

endpackage

// File: rtl/conv3x3_window_engine_if.sv
// rtl/conv3x3_window_engine_if.sv - request, tap, RAM and result signals of the window engine
interface conv3x3_window_engine_if #(
  parameter int WIDTH = 9
);

  logic                  start;
  logic [31:0]           pixel_addr;
  logic [8:0][WIDTH-1:0] kernel;
  logic [3:0]            shift;
  logic [WIDTH-1:0]      ram_data;
  logic                  tap_req;
  logic [3:0]            tap_idx;
  logic                  busy;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      result;
  logic [31:0]           result_addr;
  logic                  out_err;

  modport master (
    output start, pixel_addr, kernel, shift, ram_data, out_ready,
    input  tap_req, tap_idx, busy, out_valid, result, result_addr, out_err
  );

  modport slave (
    input  start, pixel_addr, kernel, shift, ram_data, out_ready,
    output tap_req, tap_idx, busy, out_valid, result, result_addr, out_err
  );

endinterface

// File: rtl/conv_border_mask.sv
// rtl/conv_border_mask.sv - pixel index to frame-error flag and 9-tap out-of-frame mask
module conv_border_mask
  import conv_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic [29:0] idx_i,
  output logic        err_o,
  output logic [8:0]  mask_o
);

  logic [31:0] idx_w;
  logic [31:0] row;
  logic [31:0] col;

  assign idx_w = {2'b00, idx_i};
  assign row   = idx_w / 32'(IMG_W);
  assign col   = idx_w % 32'(IMG_W);
  assign err_o = idx_w >= 32'(IMG_W * IMG_H);

  // An erroring index masks everything, so row is only trusted below IMG_H.
  always_comb begin
    mask_o = '0;
    for (int k = 0; k < 9; k++) begin
      mask_o[k] = err_o
                | ((row == 32'd0)            && (TAP_DR[k] < 0))
                | ((row == 32'(IMG_H - 1))   && (TAP_DR[k] > 0))
                | ((col == 32'd0)            && (TAP_DC[k] < 0))
                | ((col == 32'(IMG_W - 1))   && (TAP_DC[k] > 0));
    end
  end

endmodule

// File: rtl/conv3x3_window_engine.sv
// rtl/conv3x3_window_engine.sv - collects a masked 3x3 window and emits one clamped MAC result per request
module conv3x3_window_engine
  import conv_pkg::*;
#(
  parameter int WIDTH      = 9,
  parameter int RD_LATENCY = 1,
  parameter int IMG_W      = IMG_W_DEF,
  parameter int IMG_H      = IMG_H_DEF,
  parameter int ACC_W      = 22
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  conv3x3_window_engine_if.slave          eng_if
);

  localparam int LAST_COLLECT = 8 + RD_LATENCY;

  state_e                  state_q, state_d;
  logic [4:0]              cnt_q, cnt_d;
  logic [8:0]              mask_q, mask_w;
  logic                    err_q, err_w;
  logic signed [WIDTH-1:0] win_q [9];
  logic [8:0][WIDTH-1:0]   kernel_q;
  logic [3:0]              shift_q;
  logic [31:0]             addr_q;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]        result_q, result_d;
  logic [3:0]              cap_idx;
  logic [3:0]              mac_idx;
  logic                    issue;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] shifted;

  conv_border_mask #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_mask (
    .idx_i  (eng_if.pixel_addr[31:2]),
    .err_o  (err_w),
    .mask_o (mask_w)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (eng_if.start) state_d = S_COLLECT;
      S_COLLECT: if (cnt_q == 5'(LAST_COLLECT)) state_d = S_MAC;
      S_MAC:     if (cnt_q == 5'd8) state_d = S_DONE;
      S_DONE:    if (eng_if.out_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    issue              = (state_q == S_COLLECT) && (cnt_q < 5'd9);
    eng_if.tap_req     = issue;
    eng_if.tap_idx     = issue ? cnt_q[3:0] : 4'd0;
    eng_if.busy        = (state_q != S_IDLE);
    eng_if.out_valid   = (state_q == S_DONE);
    eng_if.result      = result_q;
    eng_if.result_addr = addr_q;
    eng_if.out_err     = err_q;
  end

  // One counter serves both phases; the capture slot trails issue by RD_LATENCY.
  always_comb begin
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == S_COLLECT) || (state_q == S_MAC)) begin
      cnt_d = cnt_q + 5'd1;
    end else begin
      cnt_d = '0;
    end
    cap_idx  = 4'(cnt_q - 5'(RD_LATENCY));
    mac_idx  = cnt_q[3:0];
    prod     = $signed(win_q[mac_idx]) * $signed(kernel_q[mac_idx]);
    prod_ext = {{(ACC_W - 2*WIDTH){prod[2*WIDTH-1]}}, prod};
    acc_d    = acc_q + prod_ext;
    shifted  = acc_d >>> shift_q;
    result_d = {{(WIDTH - 8){1'b0}}, clamp_u8({{(32 - ACC_W){shifted[ACC_W-1]}}, shifted})};
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q    <= '0;
      mask_q   <= '0;
      err_q    <= 1'b0;
      kernel_q <= '0;
      shift_q  <= '0;
      addr_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      for (int k = 0; k < 9; k++) begin
        win_q[k] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      if ((state_q == S_IDLE) && eng_if.start) begin
        addr_q   <= eng_if.pixel_addr;
        kernel_q <= eng_if.kernel;
        shift_q  <= eng_if.shift;
        mask_q   <= mask_w;
        err_q    <= err_w;
      end
      if (state_q == S_COLLECT) begin
        acc_q <= '0;
        if (cnt_q >= 5'(RD_LATENCY)) begin
          win_q[cap_idx] <= mask_q[cap_idx] ? '0 : $signed(eng_if.ram_data);
        end
      end
      if (state_q == S_MAC) begin
        acc_q <= acc_d;
        if (cnt_q == 5'd8) begin
          result_q <= result_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_window_engine.sv
// tb/tb_conv3x3_window_engine.sv - directed checks of the window engine at read latencies 1 and 3
module tb_conv3x3_window_engine;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [31:0]     pixel_addr;
  logic [8:0][8:0] kern;
  logic [3:0]      shf;
  logic            out_ready;
  logic [8:0]      data_tab [0:8];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  conv3x3_window_engine_if #(.WIDTH(9)) ifa ();
  conv3x3_window_engine_if #(.WIDTH(9)) ifb ();

  assign ifa.start      = start;
  assign ifa.pixel_addr = pixel_addr;
  assign ifa.kernel     = kern;
  assign ifa.shift      = shf;
  assign ifa.out_ready  = out_ready;
  assign ifb.start      = start;
  assign ifb.pixel_addr = pixel_addr;
  assign ifb.kernel     = kern;
  assign ifb.shift      = shf;
  assign ifb.out_ready  = out_ready;

  conv3x3_window_engine #(.RD_LATENCY(1)) dut_a (.clk_i(clk), .reset_i(reset), .eng_if(ifa));
  conv3x3_window_engine #(.RD_LATENCY(3)) dut_b (.clk_i(clk), .reset_i(reset), .eng_if(ifb));

  // RAM models: an invalid slot returns a nonzero junk word so misalignment shows up.
  logic       va [3];
  logic [3:0] ia [3];
  logic       vb [3];
  logic [3:0] ib [3];

  always @(posedge clk) begin
    va[0] <= ifa.tap_req;
    ia[0] <= ifa.tap_idx;
    vb[0] <= ifb.tap_req;
    ib[0] <= ifb.tap_idx;
    for (int i = 1; i < 3; i++) begin
      va[i] <= va[i-1];
      ia[i] <= ia[i-1];
      vb[i] <= vb[i-1];
      ib[i] <= ib[i-1];
    end
  end

  assign ifa.ram_data = va[0] ? data_tab[ia[0]] : 9'd77;
  assign ifb.ram_data = vb[2] ? data_tab[ib[2]] : 9'd77;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, " a tap_req"},     32'(ifa.tap_req),   32'd0);
    check_eq({tag, " a tap_idx"},     32'(ifa.tap_idx),   32'd0);
    check_eq({tag, " a busy"},        32'(ifa.busy),      32'd0);
    check_eq({tag, " a out_valid"},   32'(ifa.out_valid), 32'd0);
    check_eq({tag, " a result"},      32'(ifa.result),    32'd0);
    check_eq({tag, " a result_addr"}, ifa.result_addr,    32'd0);
    check_eq({tag, " a out_err"},     32'(ifa.out_err),   32'd0);
    check_eq({tag, " b busy"},        32'(ifb.busy),      32'd0);
    check_eq({tag, " b out_valid"},   32'(ifb.out_valid), 32'd0);
    check_eq({tag, " b result"},      32'(ifb.result),    32'd0);
    check_eq({tag, " b result_addr"}, ifb.result_addr,    32'd0);
    check_eq({tag, " b tap_req"},     32'(ifb.tap_req),   32'd0);
  endtask

  task automatic fill(input logic [8:0] d, input logic [8:0] k, input logic [3:0] s);
    for (int i = 0; i < 9; i++) begin
      data_tab[i] = d;
      kern[i]     = k;
    end
    shf = s;
  endtask

  task automatic do_req(input string tag, input logic [31:0] addr,
                        input logic [31:0] exp_res, input logic [31:0] exp_err);
    int n = 1;
    bit sa = 0;
    bit sb = 0;
    int lat_a = -1;
    int lat_b = -1;
    int tap_a = 0;
    int tap_b = 0;
    int bad_a = 0;
    int bad_b = 0;
    logic [31:0] ra = '1, rb = '1, ea = '1, eb = '1, aa = '1, ab = '1;
    @(negedge clk);
    start      = 1'b1;
    pixel_addr = addr;
    @(negedge clk);
    start = 1'b0;
    while (!(sa && sb) && n <= 60) begin
      if (ifa.tap_req) begin
        tap_a++;
        if (ifa.tap_idx != 4'(n - 1)) bad_a++;
      end
      if (ifb.tap_req) begin
        tap_b++;
        if (ifb.tap_idx != 4'(n - 1)) bad_b++;
      end
      if (ifa.out_valid && !sa) begin
        sa = 1; lat_a = n; ra = 32'(ifa.result); ea = 32'(ifa.out_err); aa = ifa.result_addr;
      end
      if (ifb.out_valid && !sb) begin
        sb = 1; lat_b = n; rb = 32'(ifb.result); eb = 32'(ifb.out_err); ab = ifb.result_addr;
      end
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check_eq({tag, " a latency"}, 32'(lat_a), 32'd20);
    check_eq({tag, " b latency"}, 32'(lat_b), 32'd22);
    check_eq({tag, " a result"},  ra, exp_res);
    check_eq({tag, " b result"},  rb, exp_res);
    check_eq({tag, " a err"},     ea, exp_err);
    check_eq({tag, " b err"},     eb, exp_err);
    check_eq({tag, " a addr"},    aa, addr);
    check_eq({tag, " b addr"},    ab, addr);
    check_eq({tag, " a taps"},    32'(tap_a), 32'd9);
    check_eq({tag, " b taps"},    32'(tap_b), 32'd9);
    check_eq({tag, " a tap order"}, 32'(bad_a), 32'd0);
    check_eq({tag, " b tap order"}, 32'(bad_b), 32'd0);
  endtask

  initial begin
    int n;
    int stall_bad;
    reset      = 1'b1;
    start      = 1'b0;
    pixel_addr = '0;
    out_ready  = 1'b1;
    fill(9'd0, 9'd0, 4'd0);
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    fill(9'd10, 9'd1, 4'd0);
    do_req("interior", 32'd4000, 32'd90, 32'd0);

    fill(9'd50, 9'd1, 4'd0);
    do_req("corner", 32'd0, 32'd200, 32'd0);

    fill(9'd20, 9'h1FF, 4'd0);
    kern[4] = 9'd8;
    do_req("last_lap", 32'd307199 * 4, 32'd100, 32'd0);

    data_tab[4] = 9'd0;
    for (int i = 0; i < 9; i++) if (i != 4) data_tab[i] = 9'd30;
    do_req("last_neg", 32'd307199 * 4, 32'd0, 32'd0);

    fill(9'd255, 9'd4, 4'd2);
    do_req("large", 32'd4000, 32'd255, 32'd0);

    // Out-of-frame request with the consumer stalling.
    fill(9'd33, 9'd1, 4'd0);
    out_ready = 1'b0;
    @(negedge clk);
    start      = 1'b1;
    pixel_addr = 32'd1228800;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!(ifa.out_valid && ifb.out_valid) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_eq("stall a valid", 32'(ifa.out_valid), 32'd1);
    check_eq("stall b valid", 32'(ifb.out_valid), 32'd1);
    stall_bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        start      = 1'b1;
        pixel_addr = 32'd4000;
      end
      if (i == 2) start = 1'b0;
      if (ifa.out_valid !== 1'b1 || ifa.result !== 9'd0 || ifa.out_err !== 1'b1 ||
          ifa.result_addr !== 32'd1228800) stall_bad++;
      if (ifb.out_valid !== 1'b1 || ifb.result !== 9'd0 || ifb.out_err !== 1'b1 ||
          ifb.result_addr !== 32'd1228800) stall_bad++;
      @(negedge clk);
    end
    check_eq("stall stable", 32'(stall_bad), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("release a busy",  32'(ifa.busy),      32'd0);
    check_eq("release b busy",  32'(ifb.busy),      32'd0);
    check_eq("release a valid", 32'(ifa.out_valid), 32'd0);
    check_eq("release b valid", 32'(ifb.out_valid), 32'd0);
    @(negedge clk);
    check_eq("no queued start a", 32'(ifa.busy), 32'd0);
    check_eq("no queued start b", 32'(ifb.busy), 32'd0);

    // Reset in the third MAC cycle of the latency-1 engine.
    for (int i = 0; i < 9; i++) begin
      data_tab[i] = 9'(i + 1);
      kern[i]     = 9'(i + 1);
    end
    shf = 4'd1;
    @(negedge clk);
    start      = 1'b1;
    pixel_addr = 32'd4000;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check_eq("pre-reset a busy", 32'(ifa.busy), 32'd1);
    reset = 1'b1;
    #1;
    check_idle_outputs("mid reset");
    @(negedge clk);
    reset = 1'b0;
    do_req("after reset", 32'd4000, 32'd142, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
